// File: rtl/gouram_tracer.sv
// Gouram pipeline tracer: snoops core handshakes, time-stamps IF/ID/EX/WB per
// instruction and emits one trace record per completed instruction in program order.

package gouram_pkg;
    // Record fields are 32 bits wide; narrower bus parameters are zero-extended into them.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] instruction;
        logic [31:0] mem_addr;
        logic        illegal;
        logic        overflow;
        logic [31:0] if_start;
        logic [31:0] if_end;
        logic [31:0] id_start;
        logic [31:0] id_end;
        logic [31:0] ex_start;
        logic [31:0] ex_end;
        logic [31:0] wb_start;
        logic [31:0] wb_end;
    } trace_format;
endpackage

module gouram_tracer
    import gouram_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH  = 32,
    parameter int INSTR_DATA_WIDTH  = 32,
    parameter int DATA_ADDR_WIDTH   = 32,
    parameter int TRACE_BUFFER_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        if_busy,
    input  logic                        if_ready,
    input  logic                        branch_decision,
    input  logic                        instr_req,
    input  logic                        instr_gnt,
    input  logic                        instr_rvalid,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic [INSTR_DATA_WIDTH-1:0] instr_rdata,
    input  logic                        id_ready,
    input  logic                        jump_done,
    input  logic                        is_decoding,
    input  logic                        illegal_instr,
    input  logic                        branch_req,
    input  logic                        ex_ready,
    input  logic                        data_req,
    input  logic                        data_gnt,
    input  logic                        data_rvalid,
    input  logic [DATA_ADDR_WIDTH-1:0]  data_addr,
    input  logic                        wb_ready,
    output trace_format                 trace_o
);
    localparam int N  = TRACE_BUFFER_SIZE;
    localparam int AW = $clog2(N);

    typedef enum logic [2:0] {PH_FETCHED, PH_ID, PH_EX, PH_WB, PH_DONE} phase_e;
    typedef struct packed {
        trace_format rec;
        phase_e      ph;
        logic        is_mem;
        logic        gnt_seen;
    } slot_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] if_start;
        logic        wrong_path;
    } fetch_t;

    logic [31:0]   cycle_q, cycle_d;
    slot_t [N-1:0] slot_q, slot_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   cnt_q, cnt_d, cnt_free;
    fetch_t [3:0]  fq_q, fq_d;
    logic [1:0]    fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
    logic [2:0]    fq_cnt_q, fq_cnt_d;
    logic          overflow_q, overflow_d;
    trace_format   trace_q, trace_d;

    logic          dec_found, ex_found, wb_found, mem_found;
    logic [AW-1:0] dec_idx, ex_idx, wb_idx, mem_idx, idx;
    logic [AW:0]   dec_off;
    logic          flush, emit, fq_pop, fq_push, alloc;
    logic          unused_status;

    assign unused_status = if_busy ^ if_ready;

    // Oldest live slot in each stage; slots are kept in program order from head.
    always_comb begin
        dec_found = 1'b0; ex_found = 1'b0; wb_found = 1'b0; mem_found = 1'b0;
        dec_idx = '0; ex_idx = '0; wb_idx = '0; mem_idx = '0; dec_off = '0; idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = head_q + AW'(i);
            if ((AW+1)'(i) < cnt_q) begin
                if (!dec_found && (slot_q[idx].ph == PH_FETCHED || slot_q[idx].ph == PH_ID)) begin
                    dec_found = 1'b1; dec_idx = idx; dec_off = (AW+1)'(i);
                end
                if (!ex_found && slot_q[idx].ph == PH_EX) begin
                    ex_found = 1'b1; ex_idx = idx;
                end
                if (!wb_found && slot_q[idx].ph == PH_WB) begin
                    wb_found = 1'b1; wb_idx = idx;
                end
                if (!mem_found && (slot_q[idx].ph == PH_EX || slot_q[idx].ph == PH_WB)
                    && slot_q[idx].is_mem && !slot_q[idx].gnt_seen) begin
                    mem_found = 1'b1; mem_idx = idx;
                end
            end
        end
    end

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        slot_d     = slot_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fq_d       = fq_q;
        fq_rd_d    = fq_rd_q;
        fq_wr_d    = fq_wr_q;
        overflow_d = overflow_q;
        flush      = 1'b0;

        if (dec_found && is_decoding) begin
            if (slot_q[dec_idx].ph == PH_FETCHED) begin
                slot_d[dec_idx].rec.id_start = cycle_q;
                slot_d[dec_idx].ph           = PH_ID;
            end
            if (id_ready) begin
                slot_d[dec_idx].rec.id_end = cycle_q;
                flush = jump_done | (branch_req & branch_decision);
                if (illegal_instr) begin
                    slot_d[dec_idx].rec.illegal  = 1'b1;
                    slot_d[dec_idx].rec.ex_start = cycle_q;
                    slot_d[dec_idx].rec.ex_end   = cycle_q;
                    slot_d[dec_idx].rec.wb_start = cycle_q;
                    slot_d[dec_idx].rec.wb_end   = cycle_q;
                    slot_d[dec_idx].ph           = PH_DONE;
                end else begin
                    slot_d[dec_idx].rec.ex_start = cycle_d;
                    slot_d[dec_idx].ph           = PH_EX;
                end
            end
        end

        if (ex_found && ex_ready) begin
            slot_d[ex_idx].rec.ex_end = cycle_q;
            slot_d[ex_idx].ph         = PH_WB;
            if (!slot_q[ex_idx].is_mem) slot_d[ex_idx].rec.wb_start = cycle_d;
        end

        // Memory ops start write-back at the data grant, which may precede ex_end.
        if (mem_found && data_req && data_gnt) begin
            slot_d[mem_idx].rec.mem_addr = 32'(data_addr);
            slot_d[mem_idx].rec.wb_start = cycle_q;
            slot_d[mem_idx].gnt_seen     = 1'b1;
        end

        if (wb_found && wb_ready &&
            (!slot_q[wb_idx].is_mem || (slot_q[wb_idx].gnt_seen && data_rvalid))) begin
            slot_d[wb_idx].rec.wb_end = cycle_q;
            slot_d[wb_idx].ph         = PH_DONE;
        end

        emit    = (cnt_q != '0) && (slot_q[head_q].ph == PH_DONE);
        trace_d = '0;
        if (emit) begin
            trace_d       = slot_q[head_q].rec;
            trace_d.valid = 1'b1;
            head_d        = head_q + AW'(1);
        end

        fq_pop  = instr_rvalid && (fq_cnt_q != 3'd0);
        fq_push = instr_req && instr_gnt && (fq_cnt_q != 3'd4 || fq_pop);
        alloc   = fq_pop && !fq_q[fq_rd_q].wrong_path && !flush;
        if (flush)
            for (int k = 0; k < 4; k++) fq_d[k].wrong_path = 1'b1;
        if (fq_push) begin
            fq_d[fq_wr_q].addr       = 32'(instr_addr);
            fq_d[fq_wr_q].if_start   = cycle_q;
            fq_d[fq_wr_q].wrong_path = 1'b0;
            fq_wr_d                  = fq_wr_q + 2'd1;
        end
        if (fq_pop) fq_rd_d = fq_rd_q + 2'd1;
        fq_cnt_d = fq_cnt_q + {2'b00, fq_push} - {2'b00, fq_pop};

        // Emit frees its slot before allocation, so a full buffer can still accept.
        cnt_free = emit ? cnt_q - (AW+1)'(1) : cnt_q;
        cnt_d    = cnt_free;
        if (flush) begin
            tail_d = dec_idx + AW'(1);
            cnt_d  = emit ? dec_off : dec_off + (AW+1)'(1);
        end else if (alloc) begin
            if (cnt_free == (AW+1)'(N)) begin
                overflow_d = 1'b1;
            end else begin
                slot_d[tail_q]                 = '0;
                slot_d[tail_q].rec.addr        = fq_q[fq_rd_q].addr;
                slot_d[tail_q].rec.instruction = 32'(instr_rdata);
                slot_d[tail_q].rec.if_start    = fq_q[fq_rd_q].if_start;
                slot_d[tail_q].rec.if_end      = cycle_q;
                slot_d[tail_q].is_mem          = (instr_rdata[6:0] == 7'b0000011) ||
                                                 (instr_rdata[6:0] == 7'b0100011);
                tail_d = tail_q + AW'(1);
                cnt_d  = cnt_free + (AW+1)'(1);
            end
        end
        trace_d.overflow = overflow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            slot_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            fq_q       <= '0;
            fq_rd_q    <= '0;
            fq_wr_q    <= '0;
            fq_cnt_q   <= '0;
            overflow_q <= 1'b0;
            trace_q    <= '0;
        end else begin
            cycle_q    <= cycle_d;
            slot_q     <= slot_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            fq_q       <= fq_d;
            fq_rd_q    <= fq_rd_d;
            fq_wr_q    <= fq_wr_d;
            fq_cnt_q   <= fq_cnt_d;
            overflow_q <= overflow_d;
            trace_q    <= trace_d;
        end
    end

    assign trace_o = trace_q;
endmodule

// File: tb/tb_gouram_tracer.sv
// Directed bench for gouram_tracer: drives core handshakes cycle by cycle and
// compares emitted records against hand-derived addresses and stamps.
module tb_gouram_tracer;
    import gouram_pkg::*;

    localparam int N = 16;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] LW   = 32'h00002083;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_busy, if_ready, branch_decision, instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata, data_addr;
    logic id_ready, jump_done, is_decoding, illegal_instr, branch_req, ex_ready;
    logic data_req, data_gnt, data_rvalid, wb_ready;
    trace_format trace_o;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] tb_cyc;
    trace_format rec_q[$];

    gouram_tracer dut (
        .clk(clk), .rst_n(rst_n), .if_busy(if_busy), .if_ready(if_ready),
        .branch_decision(branch_decision), .instr_req(instr_req), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
        .id_ready(id_ready), .jump_done(jump_done), .is_decoding(is_decoding),
        .illegal_instr(illegal_instr), .branch_req(branch_req), .ex_ready(ex_ready),
        .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_addr(data_addr), .wb_ready(wb_ready), .trace_o(trace_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;

    always @(negedge clk)
        if (trace_o.valid) rec_q.push_back(trace_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        if_busy = 0; if_ready = 1; branch_decision = 0; instr_req = 0; instr_gnt = 0;
        instr_rvalid = 0; instr_addr = '0; instr_rdata = '0; id_ready = 0; jump_done = 0;
        is_decoding = 0; illegal_instr = 0; branch_req = 0; ex_ready = 1;
        data_req = 0; data_gnt = 0; data_rvalid = 0; data_addr = '0; wb_ready = 1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w, output logic [31:0] t);
        t = tb_cyc;
        instr_req = 1; instr_gnt = 1; instr_addr = a;
        step();
        instr_req = 0; instr_gnt = 0; instr_rvalid = 1; instr_rdata = w;
        step();
        instr_rvalid = 0;
    endtask

    task automatic decode(input logic ill, input logic br);
        is_decoding = 1; id_ready = 1; illegal_instr = ill; branch_req = br; branch_decision = br;
        step();
        is_decoding = 0; id_ready = 0; illegal_instr = 0; branch_req = 0; branch_decision = 0;
    endtask

    task automatic wait_recs(input int n, input string tag);
        int k = 0;
        while (rec_q.size() < n && k < 300) begin step(); k++; end
        chk(tag, rec_q.size(), n);
    endtask

    task automatic pop_rec(output trace_format r);
        if (rec_q.size() != 0) r = rec_q.pop_front();
        else r = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        trace_format r;
        logic [31:0] t, tg;
        idle_inputs();
        #20;
        chk("rst_valid", trace_o.valid, 0);
        chk("rst_overflow", trace_o.overflow, 0);
        chk("rst_addr", trace_o.addr, 0);
        #30 rst_n = 1;
        step();

        // single addi, every stage ready
        rec_q.delete();
        fetch(32'h20, ADDI, t);
        decode(0, 0);
        wait_recs(1, "t1_count");
        pop_rec(r);
        chk("t1_addr", r.addr, 32'h20);
        chk("t1_instr", r.instruction, ADDI);
        chk("t1_illegal", r.illegal, 0);
        chk("t1_if_start", r.if_start, t);
        chk("t1_if_end", r.if_end, t + 1);
        chk("t1_id_start", r.id_start, t + 2);
        chk("t1_id_end", r.id_end, t + 2);
        chk("t1_ex_start", r.ex_start, t + 3);
        chk("t1_ex_end", r.ex_end, t + 3);
        chk("t1_wb_start", r.wb_start, t + 4);
        chk("t1_wb_end", r.wb_end, t + 4);
        chk("t1_mem_addr", r.mem_addr, 0);
        repeat (4) step();
        chk("t1_single_pulse", rec_q.size(), 0);
        chk("t1_valid_low_fields", trace_o.addr, 0);

        // straight-line 0x24..0x54
        for (int k = 0; k < 13; k++) begin
            fetch(32'h24 + 32'(k) * 4, ADDI, t);
            decode(0, 0);
        end
        wait_recs(13, "t2_count");
        repeat (5) step();
        chk("t2_no_extra", rec_q.size(), 13);
        for (int k = 0; k < 13; k++) begin
            pop_rec(r);
            chk($sformatf("t2_addr%0d", k), r.addr, 32'h24 + 32'(k) * 4);
        end

        // taken branch at 0x30 with 0x34 buffered and 0x38 outstanding
        instr_req = 1; instr_gnt = 1; instr_addr = 32'h30;
        step();
        instr_rvalid = 1; instr_rdata = BEQ; instr_addr = 32'h34;
        step();
        instr_rdata = ADDI; instr_addr = 32'h38;
        step();
        instr_req = 0; instr_gnt = 0; instr_rvalid = 0;
        decode(0, 1);
        instr_rvalid = 1; instr_rdata = ADDI;
        step();
        instr_rvalid = 0;
        fetch(32'h80, ADDI, t);
        decode(0, 0);
        wait_recs(2, "t3_count");
        repeat (10) step();
        chk("t3_no_extra", rec_q.size(), 2);
        pop_rec(r);
        chk("t3_branch_addr", r.addr, 32'h30);
        pop_rec(r);
        chk("t3_target_addr", r.addr, 32'h80);

        // load at 0x40, response 3 cycles after grant
        fetch(32'h40, LW, t);
        decode(0, 0);
        data_req = 1; data_gnt = 1; data_addr = 32'h100; tg = tb_cyc;
        step();
        data_req = 0; data_gnt = 0; data_addr = '0;
        step(); step();
        data_rvalid = 1;
        step();
        data_rvalid = 0;
        wait_recs(1, "t4_count");
        pop_rec(r);
        chk("t4_addr", r.addr, 32'h40);
        chk("t4_mem_addr", r.mem_addr, 32'h100);
        chk("t4_ex_start", r.ex_start, t + 3);
        chk("t4_wb_start", r.wb_start, tg);
        chk("t4_wb_len", r.wb_end - r.wb_start, 3);

        // illegal instruction at 0x44
        fetch(32'h44, 32'h00000000, t);
        decode(1, 0);
        wait_recs(1, "t5_count");
        pop_rec(r);
        chk("t5_addr", r.addr, 32'h44);
        chk("t5_illegal", r.illegal, 1);
        chk("t5_id_end", r.id_end, t + 2);
        chk("t5_ex_end", r.ex_end, t + 2);
        chk("t5_wb_end", r.wb_end, t + 2);

        // overflow: N+2 fetches with nothing retiring
        ex_ready = 0;
        for (int k = 0; k < N + 2; k++) fetch(32'h200 + 32'(k) * 4, ADDI, t);
        chk("t6_ovf_idle", trace_o.overflow, 1);
        chk("t6_valid_idle", trace_o.valid, 0);
        ex_ready = 1;
        is_decoding = 1; id_ready = 1;
        repeat (N) step();
        is_decoding = 0; id_ready = 0;
        wait_recs(N, "t6_count");
        repeat (5) step();
        chk("t6_no_extra", rec_q.size(), N);
        for (int k = 0; k < N; k++) begin
            pop_rec(r);
            chk($sformatf("t6_addr%0d", k), r.addr, 32'h200 + 32'(k) * 4);
            chk($sformatf("t6_ovf%0d", k), r.overflow, 1);
        end

        // asynchronous reset with an instruction in flight
        fetch(32'h300, ADDI, t);
        decode(0, 0);
        #2 rst_n = 0;
        #1;
        chk("rst2_overflow", trace_o.overflow, 0);
        chk("rst2_valid", trace_o.valid, 0);
        step(); step();
        rst_n = 1;
        repeat (10) step();
        chk("rst2_no_partial", rec_q.size(), 0);
        fetch(32'h20, ADDI, t);
        decode(0, 0);
        wait_recs(1, "rst2_count");
        pop_rec(r);
        chk("rst2_addr", r.addr, 32'h20);
        chk("rst2_rec_overflow", r.overflow, 0);
        chk("rst2_if_start", r.if_start, t);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
